// File: rtl/aoi211_pipe_bank_if.sv
// rtl/aoi211_pipe_bank_if.sv - operand, control, scan and result bundle for aoi211_pipe_bank
interface aoi211_pipe_bank_if #(
  parameter int WIDTH = 8
);
  logic             E;
  logic             SE;
  logic             SI;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] A2;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             V_IN;
  logic [WIDTH-1:0] ZN;
  logic             V_OUT;
  logic             SO;

  modport master (
    output E, SE, SI, A1, A2, B, C, V_IN,
    input  ZN, V_OUT, SO
  );

  modport slave (
    input  E, SE, SI, A1, A2, B, C, V_IN,
    output ZN, V_OUT, SO
  );
endinterface

// File: rtl/aoi211_pipe_bank.sv
// rtl/aoi211_pipe_bank.sv - WIDTH-channel AOI211/OAI211 bank with STAGES-deep scannable pipeline
module aoi211_pipe_bank #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int MODE   = 0
) (
  input  logic              CLK,
  input  logic              RN,
  inout  wire               VDD,
  inout  wire               VSS,
  aoi211_pipe_bank_if.slave bus
);

  localparam int NBITS = WIDTH * STAGES;

  // Out-of-range parameters stop elaboration instead of building a malformed pipe.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("aoi211_pipe_bank: WIDTH must be 1..64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aoi211_pipe_bank: STAGES must be 1..4");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("aoi211_pipe_bank: MODE must be 0 or 1");
  end

  // Stage k occupies pipe[k*WIDTH +: WIDTH]; bit order equals scan order, SI enters at bit 0.
  logic [NBITS-1:0]  pipe;
  logic [NBITS-1:0]  scan_nxt;
  logic [NBITS-1:0]  cap_nxt;
  logic [NBITS-1:0]  pipe_nxt;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vld_cap;
  logic [STAGES-1:0] vld_nxt;
  logic [WIDTH-1:0]  f;

  // Power pins are connection-only; fold them into a sink so they have a reader.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  if (MODE == 0) begin : g_aoi
    assign f = ~((bus.A1 & bus.A2) | bus.B | bus.C);
  end else begin : g_oai
    assign f = ~((bus.A1 | bus.A2) & bus.B & bus.C);
  end

  // Next-state selection; ternaries (not if) so an X on SE or E propagates into the flops.
  always_comb begin
    scan_nxt    = pipe;
    scan_nxt[0] = bus.SI;
    for (int i = 1; i < NBITS; i++) begin
      scan_nxt[i] = pipe[i-1];
    end

    cap_nxt            = pipe;
    cap_nxt[WIDTH-1:0] = f;
    for (int i = WIDTH; i < NBITS; i++) begin
      cap_nxt[i] = pipe[i-WIDTH];
    end

    vld_cap    = vld;
    vld_cap[0] = bus.V_IN;
    for (int k = 1; k < STAGES; k++) begin
      vld_cap[k] = vld[k-1];
    end

    pipe_nxt = bus.SE ? scan_nxt : (bus.E ? cap_nxt : pipe);
    vld_nxt  = bus.SE ? vld      : (bus.E ? vld_cap : vld);
  end

  // Pipeline and valid flops; reset discards everything in flight.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      pipe <= '0;
      vld  <= '0;
    end else begin
      pipe <= pipe_nxt;
      vld  <= vld_nxt;
    end
  end

  assign bus.ZN    = pipe[NBITS-1 -: WIDTH];
  assign bus.V_OUT = vld[STAGES-1];
  assign bus.SO    = pipe[NBITS-1];

endmodule
